// File: rtl/gpu_pkg.sv
// Shared GPU definitions: AXI write-response codes and texture uploader states.
package gpu_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_RESP
  } upl_state_e;

endpackage

// File: rtl/texture_uploader.sv
// AXI4-Lite write master: copies cmd_len stream words to incrementing addresses, one write outstanding.
// Latency 3 cycles/word unstalled; every output is a register or state decode, so stalls never ripple through.
module texture_uploader
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] sdata,
  input  logic                  svalid,
  output logic                  sready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  upl_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  aw_acc_q, aw_acc_d;
  logic                  w_acc_q, w_acc_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // A valid is live in SEND until its own channel has been accepted.
  assign awvalid   = (state_q == ST_SEND) && !aw_acc_q;
  assign wvalid    = (state_q == ST_SEND) && !w_acc_q;
  assign cmd_ready = (state_q == ST_IDLE);
  assign sready    = (state_q == ST_FETCH);
  assign bready    = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign awaddr    = addr_q;
  assign awprot    = 3'b000;
  assign wdata     = wdata_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    aw_acc_d = aw_acc_q;
    w_acc_d  = w_acc_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          cnt_d  = cmd_len;
          err_d  = 1'b0;
          if (cmd_len == '0) done_d = 1'b1;
          else               state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (svalid) begin
          wdata_d  = sdata;
          aw_acc_d = 1'b0;
          w_acc_d  = 1'b0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (awvalid && awready) aw_acc_d = 1'b1;
        if (wvalid && wready)   w_acc_d  = 1'b1;
        if (aw_acc_d && w_acc_d) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bvalid) begin
          if (bresp != RESP_OKAY) err_d = 1'b1;
          addr_d = addr_q + ADDR_STEP;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      aw_acc_q <= 1'b0;
      w_acc_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      aw_acc_q <= aw_acc_d;
      w_acc_q  <= w_acc_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_texture_uploader.sv
// Directed bench for texture_uploader: acts as stream source and AXI4-Lite slave, checks each step.
module tb_texture_uploader;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] sdata;
  logic        svalid;
  logic        sready;
  logic [21:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        busy;
  logic        done;
  logic        err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int cyc0;

  texture_uploader #(.ADDR_WIDTH(22), .DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .sdata(sdata), .svalid(svalid), .sready(sready),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge after acceptance.
  task automatic issue_cmd(input logic [21:0] a, input logic [15:0] l);
    int k;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // One full word: stream beat, AW/W with given ready delays, B after bdly cycles.
  task automatic do_word(input logic [21:0] ea, input logic [31:0] d, input int sdly,
                         input int awdly, input int wdly, input int bdly, input logic [1:0] rsp);
    int k;
    int c;
    int awh;
    int wh;
    logic av;
    logic wv;
    for (int i = 0; i < sdly; i++) begin
      svalid = 1'b0;
      chk("sready_fetch", sready, 1'b1);
      @(negedge clk);
    end
    svalid = 1'b1;
    sdata  = d;
    k = 0;
    while (!sready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("sready_wait", sready, 1'b1);
    @(negedge clk);
    svalid = 1'b0;
    sdata  = 32'hDEAD_BEEF;
    chk("sready_send", sready, 1'b0);
    c = 0; awh = 0; wh = 0;
    while ((awh == 0 || wh == 0) && c < 30) begin
      awready = (c >= awdly);
      wready  = (c >= wdly);
      av = awvalid;
      wv = wvalid;
      chk("awvalid_lvl", av, (awh == 0));
      chk("wvalid_lvl", wv, (wh == 0));
      if (av) chk("awaddr_stable", awaddr, ea);
      if (wv) chk("wdata_stable", wdata, d);
      chk("awprot", awprot, 3'b000);
      chk("bready_send", bready, 1'b0);
      @(negedge clk);
      if (av && awready) awh++;
      if (wv && wready)  wh++;
      c++;
    end
    awready = 1'b0;
    wready  = 1'b0;
    chk("aw_once", awh, 1);
    chk("w_once", wh, 1);
    chk("awvalid_resp", awvalid, 1'b0);
    chk("wvalid_resp", wvalid, 1'b0);
    for (int i = 0; i < bdly; i++) begin
      chk("bready_wait", bready, 1'b1);
      @(negedge clk);
    end
    chk("bready_resp", bready, 1'b1);
    bvalid = 1'b1;
    bresp  = rsp;
    @(negedge clk);
    bvalid = 1'b0;
    bresp  = RESP_OKAY;
  endtask

  initial begin
    rst = 1'b1;
    cmd_addr = '0; cmd_len = '0; cmd_valid = 1'b0;
    sdata = '0; svalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = RESP_OKAY; bvalid = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_sready", sready, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_awaddr", awaddr, 22'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic write, zero stall: 9 cycles from first FETCH to done.
    issue_cmd(22'h100, 16'd3);
    cyc0 = cyc;
    chk("basic_busy", busy, 1'b1);
    do_word(22'h100, 32'hA, 0, 0, 0, 0, RESP_OKAY);
    chk("basic_done_mid", done, 1'b0);
    do_word(22'h104, 32'hB, 0, 0, 0, 0, RESP_OKAY);
    do_word(22'h108, 32'hC, 0, 0, 0, 0, RESP_OKAY);
    chk("basic_cycles", cyc - cyc0, 9);
    chk("basic_done", done, 1'b1);
    chk("basic_err", err, 1'b0);
    chk("basic_idle", busy, 1'b0);
    @(negedge clk);
    chk("basic_done_pulse", done, 1'b0);

    // Channel skew both ways.
    issue_cmd(22'h200, 16'd2);
    do_word(22'h200, 32'h1111_2222, 0, 4, 0, 0, RESP_OKAY);
    do_word(22'h204, 32'h3333_4444, 0, 0, 4, 0, RESP_OKAY);
    chk("skew_done", done, 1'b1);
    @(negedge clk);

    // Error response is sticky, transfer continues, next command clears it.
    issue_cmd(22'h300, 16'd2);
    do_word(22'h300, 32'h5555, 0, 0, 0, 0, RESP_SLVERR);
    chk("err_after_first", err, 1'b1);
    do_word(22'h304, 32'h6666, 0, 0, 0, 0, RESP_OKAY);
    chk("err_done", done, 1'b1);
    chk("err_sticky", err, 1'b1);
    @(negedge clk);
    chk("err_hold_idle", err, 1'b1);
    issue_cmd(22'h400, 16'd1);
    chk("err_cleared", err, 1'b0);
    do_word(22'h400, 32'h7777, 0, 0, 0, 0, RESP_OKAY);
    chk("err_clr_done", done, 1'b1);
    @(negedge clk);

    // Zero length: done next cycle, no AXI traffic.
    issue_cmd(22'h500, 16'd0);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_awvalid", awvalid, 1'b0);
    chk("zero_sready", sready, 1'b0);
    @(negedge clk);
    chk("zero_done_pulse", done, 1'b0);
    chk("zero_awvalid2", awvalid, 1'b0);

    // Address wrap past the top.
    issue_cmd(22'h3FFFFC, 16'd2);
    do_word(22'h3FFFFC, 32'h8888, 0, 0, 0, 0, RESP_OKAY);
    do_word(22'h000000, 32'h9999, 0, 0, 0, 0, RESP_OKAY);
    chk("wrap_done", done, 1'b1);
    @(negedge clk);

    // Stalled stream and slow B.
    issue_cmd(22'h1000, 16'd4);
    for (int i = 0; i < 4; i++)
      do_word(22'h1000 + 22'(4 * i), 32'hC0DE_0000 + 32'(i), $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom_range(0, 2), 5, RESP_OKAY);
    chk("stall_done", done, 1'b1);
    chk("stall_err", err, 1'b0);
    @(negedge clk);

    // Reset while awvalid is high drops valids between clock edges.
    issue_cmd(22'h2000, 16'd2);
    svalid = 1'b1;
    sdata  = 32'hFACE;
    @(negedge clk);
    svalid = 1'b0;
    chk("mid_awvalid", awvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_awvalid", awvalid, 1'b0);
    chk("mid_rst_wvalid", wvalid, 1'b0);
    chk("mid_rst_sready", sready, 1'b0);
    chk("mid_rst_bready", bready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    issue_cmd(22'h3000, 16'd1);
    do_word(22'h3000, 32'hBEEF, 0, 0, 0, 0, RESP_OKAY);
    chk("post_rst_done", done, 1'b1);
    chk("post_rst_err", err, 1'b0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
